// File: rtl/gsim_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gsim_host_ctrl
// Brief    : Host-side sequencer for the GSIM solver core. Buffers N
//            right-hand-side words from an upstream valid/ready stream,
//            replays them to the solver as one gap-free in_en burst, captures
//            the N-word result burst, then returns it downstream over
//            valid/ready with a last-word marker.
// Options  : `define GSIM_HOST_TIMEOUT_EN to build the WAIT_X watchdog
//            (TIMEOUT_CYC cycles, sticky err). Without it err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module gsim_host_ctrl #(
  parameter int N           = 16,
  parameter int BW          = 16,
  parameter int XW          = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  input  logic [BW-1:0] s_data,
  output logic          s_ready,
  output logic          in_en,
  output logic [BW-1:0] b_in,
  input  logic          out_valid,
  input  logic [XW-1:0] x_out,
  output logic          m_valid,
  output logic [XW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          err
);

  localparam int            c_CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(N - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

  // Parameter sanity: the shared counter relies on N being a power of two.
  if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("gsim_host_ctrl: N must be a power of two >= 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("gsim_host_ctrl: TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_SEND_B  = 3'd1,
    ST_WAIT_X  = 3'd2,
    ST_COLLECT = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_CW-1:0]   r_cnt;
  logic [c_CW-1:0]   w_cnt_nxt;
  logic [c_CW-1:0]   w_cnt_inc;

  logic [BW-1:0]     r_b_buf [N];
  logic [XW-1:0]     r_x_buf [N];

  logic              r_s_ready, w_s_ready_nxt;
  logic              r_in_en,   w_in_en_nxt;
  logic [BW-1:0]     r_b_in,    w_b_in_nxt;
  logic              r_m_valid, w_m_valid_nxt;
  logic [XW-1:0]     r_m_data,  w_m_data_nxt;
  logic              r_m_last,  w_m_last_nxt;
  logic              r_busy,    w_busy_nxt;

  logic              w_b_we;
  logic              w_x_we;
  logic [c_CW-1:0]   w_x_idx;

`ifdef GSIM_HOST_TIMEOUT_EN
  localparam int              c_WDW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_WDW-1:0] c_WD_LAST = c_WDW'(TIMEOUT_CYC - 1);
  localparam logic [c_WDW-1:0] c_WD_ONE  = c_WDW'(1);
  logic [c_WDW-1:0]  r_wd;
  logic              w_wd_start;
  logic              r_err, w_err_nxt;
`endif

  assign w_cnt_inc = r_cnt + c_CNT_ONE;

  // Next-state, counter, buffer write strobes and next registered outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_s_ready_nxt = r_s_ready;
    w_in_en_nxt   = 1'b0;
    w_b_in_nxt    = '0;
    w_m_valid_nxt = r_m_valid;
    w_m_data_nxt  = r_m_data;
    w_m_last_nxt  = r_m_last;
    w_b_we        = 1'b0;
    w_x_we        = 1'b0;
    w_x_idx       = r_cnt;
`ifdef GSIM_HOST_TIMEOUT_EN
    w_wd_start    = 1'b0;
    w_err_nxt     = r_err;
`endif
    case (r_state)
      ST_LOAD: begin
        if (s_valid && r_s_ready) begin
          w_b_we = 1'b1;
`ifdef GSIM_HOST_TIMEOUT_EN
          w_err_nxt = 1'b0;
`endif
          if (r_cnt == c_CNT_LAST) begin
            // Word 0 goes out on the very next cycle (1-cycle turnaround).
            w_cnt_nxt     = '0;
            w_s_ready_nxt = 1'b0;
            w_in_en_nxt   = 1'b1;
            w_b_in_nxt    = r_b_buf[0];
            w_state_nxt   = ST_SEND_B;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      ST_SEND_B: begin
        // The registered b_in shows b_buf[cnt]; queue up b_buf[cnt+1].
        if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt = '0;
          if (out_valid) begin
            // A result that lands on the last in_en cycle is kept.
            w_x_we      = 1'b1;
            w_x_idx     = '0;
            w_cnt_nxt   = c_CNT_ONE;
            w_state_nxt = ST_COLLECT;
          end else begin
            w_state_nxt = ST_WAIT_X;
`ifdef GSIM_HOST_TIMEOUT_EN
            w_wd_start  = 1'b1;
`endif
          end
        end else begin
          w_in_en_nxt = 1'b1;
          w_b_in_nxt  = r_b_buf[w_cnt_inc];
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      ST_WAIT_X: begin
        if (out_valid) begin
          w_x_we      = 1'b1;
          w_x_idx     = '0;
          w_cnt_nxt   = c_CNT_ONE;
          w_state_nxt = ST_COLLECT;
        end
`ifdef GSIM_HOST_TIMEOUT_EN
        else if (r_wd == c_WD_LAST) begin
          w_err_nxt     = 1'b1;
          w_cnt_nxt     = '0;
          w_s_ready_nxt = 1'b1;
          w_state_nxt   = ST_LOAD;
        end
`endif
      end
      ST_COLLECT: begin
        if (out_valid) begin
          w_x_we = 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            // x_buf[0] was captured long ago, so it can be presented now.
            w_cnt_nxt     = '0;
            w_m_valid_nxt = 1'b1;
            w_m_data_nxt  = r_x_buf[0];
            w_m_last_nxt  = 1'b0;
            w_state_nxt   = ST_DRAIN;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      ST_DRAIN: begin
        if (m_ready) begin
          if (r_cnt == c_CNT_LAST) begin
            w_m_valid_nxt = 1'b0;
            w_m_data_nxt  = '0;
            w_m_last_nxt  = 1'b0;
            w_cnt_nxt     = '0;
            w_s_ready_nxt = 1'b1;
            w_state_nxt   = ST_LOAD;
          end else begin
            w_m_data_nxt = r_x_buf[w_cnt_inc];
            w_m_last_nxt = (w_cnt_inc == c_CNT_LAST);
            w_cnt_nxt    = w_cnt_inc;
          end
        end
      end
      default: begin
        w_cnt_nxt     = '0;
        w_s_ready_nxt = 1'b1;
        w_m_valid_nxt = 1'b0;
        w_m_data_nxt  = '0;
        w_m_last_nxt  = 1'b0;
        w_state_nxt   = ST_LOAD;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_LOAD);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_LOAD;
      r_cnt     <= '0;
      r_s_ready <= 1'b1;
      r_in_en   <= 1'b0;
      r_b_in    <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_s_ready <= w_s_ready_nxt;
      r_in_en   <= w_in_en_nxt;
      r_b_in    <= w_b_in_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_m_data  <= w_m_data_nxt;
      r_m_last  <= w_m_last_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Word buffers; contents are meaningless after reset so they carry none
  always_ff @(posedge clk) begin
    if (w_b_we) r_b_buf[r_cnt]   <= s_data;
    if (w_x_we) r_x_buf[w_x_idx] <= x_out;
  end

`ifdef GSIM_HOST_TIMEOUT_EN
  // Watchdog: counts WAIT_X cycles from zero, err is sticky until a new b word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
      if (w_wd_start)
        r_wd <= '0;
      else if (r_state == ST_WAIT_X)
        r_wd <= r_wd + c_WD_ONE;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign s_ready = r_s_ready;
  assign in_en   = r_in_en;
  assign b_in    = r_b_in;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;
  assign busy    = r_busy;

endmodule
`default_nettype wire

// File: doc/gsim_host_ctrl.md
Name: gsim_host_ctrl

Overview:
- Host-side counterpart of the GSIM solver core.
- Accepts 16 right-hand-side words b1..b16 from an upstream valid/ready stream and buffers them.
- Replays the buffered words to the solver as a contiguous in_en burst, then captures the solver's 16-word out_valid/x_out result burst.
- Returns the captured results to a downstream consumer over valid/ready, with a last-word marker.

Parameters:
- N, 16, words per solve (b count = x count); must be a power of 2.
- BW, 16, b word width.
- XW, 32, x word width.
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with GSIM_HOST_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream b word valid.
- s_data  in  BW  upstream b word.
- s_ready  out  1  block can accept a b word.
- in_en  out  1  b_in valid to solver; one word per cycle.
- b_in  out  BW  b word to solver.
- out_valid  in  1  solver result word valid.
- x_out  in  XW  solver result word.
- m_valid  out  1  result word valid to consumer.
- m_data  out  XW  result word.
- m_last  out  1  high with the N-th result word.
- m_ready  in  1  consumer accepts m_data.
- busy  out  1  high in every state except LOAD.
- err  out  1  watchdog expiry flag; tied 0 when the macro is off.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
- All outputs are registered.
- Reset values: state=LOAD, cnt=0, s_ready=1, in_en=0, b_in=0, m_valid=0, m_data=0, m_last=0, busy=0, err=0.
- Reset mid-operation aborts the current solve. Buffer contents are don't-care after reset.
- Storage: b_buf[N] of BW bits and x_buf[N] of XW bits. One shared log2(N)-bit counter cnt.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready, write b_buf[cnt]=s_data and increment cnt.
  - Gaps in s_valid are allowed.
  - On the transfer with cnt==N-1: cnt->0, s_ready->0, go to SEND_B.
- SEND_B:
  - Drive in_en=1 and b_in=b_buf[cnt] on N consecutive cycles, in order b1..bN. No gaps.
  - Increment cnt every cycle.
  - After the N-th word, the next cycle has in_en=0 and b_in=0; go to WAIT_X with cnt=0.
  - First in_en is asserted on the cycle after the N-th upstream handshake (1-cycle turnaround).
- WAIT_X:
  - Idle until out_valid=1.
  - The first out_valid cycle is itself a capture: x_buf[0]=x_out, cnt=1, go to COLLECT.
  - If the last in_en cycle and out_valid coincide, the capture takes priority.
- COLLECT:
  - Each cycle with out_valid=1: x_buf[cnt]=x_out, cnt+1.
  - Cycles with out_valid=0 are held (no capture, no advance).
  - After the capture at cnt==N-1: cnt->0, go to DRAIN.
- DRAIN:
  - m_valid=1, m_data=x_buf[cnt], m_last=(cnt==N-1).
  - m_data and m_last update in the cycle after each m_valid&&m_ready handshake.
  - m_data is held stable while m_ready=0.
  - After the handshake at cnt==N-1: m_valid->0, m_last->0, cnt->0, s_ready->1, go to LOAD.
  - Back-to-back solves are allowed: the next b word may be accepted on the cycle after the last m handshake.
- out_valid outside WAIT_X/COLLECT is ignored. s_valid outside LOAD is ignored (s_ready=0).
- Counter wrap: cnt is exactly log2(N) bits. Transitions are decided on cnt==N-1, never on overflow.
- Pure data movement: no arithmetic on b or x; widths are passed through unchanged.

Optional Feature:
- Macro: GSIM_HOST_TIMEOUT_EN.
- Defined:
  - A watchdog counter of width clog2(TIMEOUT_CYC+1) clears on entry to WAIT_X and increments each cycle spent in WAIT_X.
  - When it reaches TIMEOUT_CYC before out_valid arrives: err=1 sticky, state->LOAD, cnt->0, s_ready->1.
  - err clears only on reset or on the next accepted upstream b word.
  - COLLECT is not watched.
- Undefined: no watchdog logic is built; err is constant 0; WAIT_X waits indefinitely.

Test Plan:
- Reset mid-SEND_B (after 5 in_en pulses) -> next cycle in_en=0, s_ready=1, busy=0, m_valid=0, all outputs at reset values.
- Load b=0x0001..0x0010 with s_valid toggling 1/0 -> s_ready drops after the 16th transfer; next cycle starts 16 contiguous in_en cycles with b_in=0x0001..0x0010 in order; then in_en=0.
- Solver model returns x=0x1000_0000+i on 16 contiguous out_valid cycles, m_ready=1 -> m_data sequence 0x1000_0000..0x1000_000F, m_last high only on 0x1000_000F, then s_ready=1.
- out_valid with 3-cycle gaps between words, m_ready toggling 0/1 -> all 16 words captured and emitted in order; m_data held stable during m_ready=0 cycles.
- Two solves back-to-back, second b set 0xFFFF..0xFFF0 -> second in_en burst carries the new values; no stale words from the first solve on b_in or m_data.
- With GSIM_HOST_TIMEOUT_EN and TIMEOUT_CYC=64, solver never asserts out_valid -> err=1 at WAIT_X entry+64 cycles, state returns to LOAD, err clears on the next b handshake. Without the macro -> err stays 0 and busy stays 1.
